// File: rtl/st_arb_pkg.sv
// rtl/st_arb_pkg.sv - shared types and sizes for the streaming channel arbiter
package st_arb_pkg;

  localparam int NUM_IN   = 4;
  localparam int IDX_W    = $clog2(NUM_IN);
  localparam int DATA_W   = 12;
  localparam int CH_W     = 5;
  localparam int OUT_CH_W = IDX_W + CH_W;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One Avalon-ST beat as seen on the output side (channel already prefixed)
  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [OUT_CH_W-1:0] channel;
    logic                sop;
    logic                eop;
  } beat_t;

endpackage

// File: rtl/st_rr_pick.sv
// rtl/st_rr_pick.sv - combinational round-robin picker: first requester at or after ptr
module st_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the closest requester to ptr wins;
  // N is a power of two, so IW-bit addition wraps naturally.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/st_channel_arbiter.sv
// rtl/st_channel_arbiter.sv - packet-locked round-robin Avalon-ST arbiter with channel prefixing
module st_channel_arbiter
  import st_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN*CH_W-1:0]   in_channel,
  input  logic [NUM_IN-1:0]        in_sop,
  input  logic [NUM_IN-1:0]        in_eop,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CH_W-1:0]      out_channel,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     locked,
  output logic                     proto_err
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic             first_beat;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             load_en;
  logic             accept;
  logic             gi_valid, gi_sop, gi_eop;
  beat_t            sel_beat;
  beat_t            out_beat;

  st_rr_pick #(.N(NUM_IN), .IW(IDX_W)) u_pick (
    .req (in_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Output register may take a new beat when empty or being drained this cycle
  assign load_en = !out_valid || out_ready;
  assign accept  = (state == LOCKED) && gi_valid && load_en;
  assign locked  = (state == LOCKED);

  assign out_data    = out_beat.data;
  assign out_channel = out_beat.channel;
  assign out_sop     = out_beat.sop;
  assign out_eop     = out_beat.eop;

  // Select the granted input's beat and prefix its channel with the grant index
  always_comb begin
    gi_valid = 1'b0;
    gi_sop   = 1'b0;
    gi_eop   = 1'b0;
    sel_beat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        gi_valid         = in_valid[i];
        gi_sop           = in_sop[i];
        gi_eop           = in_eop[i];
        sel_beat.data    = in_data[i*DATA_W +: DATA_W];
        sel_beat.channel = {grant_idx, in_channel[i*CH_W +: CH_W]};
        sel_beat.sop     = in_sop[i];
        sel_beat.eop     = in_eop[i];
      end
    end
  end

  // Next-state and ready: only the granted input sees ready, and only when the output can load
  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = LOCKED;
      end
      LOCKED: begin
        in_ready[grant_idx] = load_en;
        if (accept && gi_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant, round-robin pointer and protocol-error tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_idx  <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        grant_idx  <= pick_idx;
        first_beat <= 1'b1;
      end
      if (accept) begin
        first_beat <= 1'b0;
        if (first_beat && !gi_sop) proto_err <= 1'b1;
        // Just-finished input drops to lowest priority for the next arbitration
        if (gi_eop) rr_ptr <= grant_idx + IDX_W'(1);
      end
    end
  end

  // Output register stage: load on accept, drop valid when drained, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_beat  <= sel_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
